// File: rtl/regfile_dump_if.sv
// regfile_dump_if: valid/ready word stream carried from the register-file
// dumper to the message-decoder debug/output path.
//   master - the dumper (drives the word, index and last flag)
//   slave  - the downstream consumer (drives out_ready)
interface regfile_dump_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_index;
    logic        out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: sequential reader for the ARMv4 register file.
// On a start pulse it walks register indices FIRST_REG..LAST_REG through
// one read port (READ captures a word, PRESENT hands it downstream) and
// pulses done once the final beat has been accepted.
// busy steers the external read-address mux away from the core.
//
// Optional feature macro: REGDUMP_CHECKSUM_EN
//   defined   - a 32-bit running sum of the captured words is emitted as an
//               extra final beat (index 4'hF, out_last=1)
//   undefined - no accumulator; out_last marks the LAST_REG beat
module regfile_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 15
) (
    input  logic           clk,
    input  logic           rst,        // asynchronous, active-low
    input  logic           start,
    output logic [3:0]     rf_addr,
    input  logic [31:0]    rf_data,
    regfile_dump_if.master dump_out,
    output logic           busy,
    output logic           done
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_READ    = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;
    localparam logic [1:0] ST_FINISH  = 2'd3;

    localparam logic [3:0] FIRST_IDX = 4'(FIRST_REG);
    localparam logic [3:0] LAST_IDX  = 4'(LAST_REG);

    logic [1:0]  state_reg, state_next;
    logic [3:0]  idx_reg, idx_next;
    logic [31:0] data_reg, data_next;
    logic [3:0]  index_reg, index_next;
    logic        last_reg, last_next;
    logic        at_last_idx;

`ifdef REGDUMP_CHECKSUM_EN
    logic [31:0] sum_reg, sum_next;
    logic        sum_beat_reg, sum_beat_next;
`endif

    // The walk stops here; idx is never incremented past LAST_REG so it cannot wrap.
    assign at_last_idx = (idx_reg == LAST_IDX);

    // Status outputs decode straight from the state so an asynchronous
    // reset clears them in the same instant the FSM returns to IDLE.
    assign busy               = (state_reg == ST_READ) || (state_reg == ST_PRESENT);
    assign done               = (state_reg == ST_FINISH);
    assign dump_out.out_valid = (state_reg == ST_PRESENT);

    // The read address is the walk index in every state, so the external
    // mux sees a steady value even while PRESENT is stalled.
    assign rf_addr            = idx_reg;

    assign dump_out.out_data  = data_reg;
    assign dump_out.out_index = index_reg;
    assign dump_out.out_last  = last_reg;

    // Next-state, capture and walk-index logic.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        data_next  = data_reg;
        index_next = index_reg;
        last_next  = last_reg;
`ifdef REGDUMP_CHECKSUM_EN
        sum_next      = sum_reg;
        sum_beat_next = sum_beat_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                // start is only looked at here; a request while busy is dropped.
                if (start) begin
                    idx_next   = FIRST_IDX;
                    state_next = ST_READ;
`ifdef REGDUMP_CHECKSUM_EN
                    sum_next      = 32'd0;
                    sum_beat_next = 1'b0;
`endif
                end
            end

            ST_READ: begin
                // rf_data is combinational from rf_addr=idx; latch it so the
                // presented word is frozen regardless of later writes.
                data_next  = rf_data;
                index_next = idx_reg;
`ifdef REGDUMP_CHECKSUM_EN
                // The sum beat, not the LAST_REG word, closes the dump.
                last_next = 1'b0;
                sum_next  = sum_reg + rf_data;
`else
                last_next = at_last_idx;
`endif
                state_next = ST_PRESENT;
            end

            ST_PRESENT: begin
                if (dump_out.out_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
                    if (sum_beat_reg) begin
                        state_next = ST_FINISH;
                    end else if (at_last_idx) begin
                        // Stay in PRESENT and offer the checksum as one more beat.
                        data_next     = sum_reg;
                        index_next    = 4'hF;
                        last_next     = 1'b1;
                        sum_beat_next = 1'b1;
                    end else begin
                        idx_next   = idx_reg + 4'd1;
                        state_next = ST_READ;
                    end
`else
                    if (at_last_idx) begin
                        state_next = ST_FINISH;
                    end else begin
                        idx_next   = idx_reg + 4'd1;
                        state_next = ST_READ;
                    end
`endif
                end
            end

            ST_FINISH: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any dump in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= 4'd0;
            data_reg  <= 32'd0;
            index_reg <= 4'd0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
            index_reg <= index_next;
            last_reg  <= last_next;
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    // Running checksum and the flag marking the extra checksum beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_reg      <= 32'd0;
            sum_beat_reg <= 1'b0;
        end else begin
            sum_reg      <= sum_next;
            sum_beat_reg <= sum_beat_next;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed bench for regfile_dump. One full-range instance
// (0..15) and one subrange instance (14..15), each with its own register
// file model. Honours REGDUMP_CHECKSUM_EN when it is defined for the build.
module tb_regfile_dump;

`ifdef REGDUMP_CHECKSUM_EN
    localparam int MAIN_BEATS = 17;
    localparam int SUB_BEATS  = 3;
    localparam int EXTRA_CYC  = 1;
`else
    localparam int MAIN_BEATS = 16;
    localparam int SUB_BEATS  = 2;
    localparam int EXTRA_CYC  = 0;
`endif

    logic        clk;
    logic        rst;

    logic        start;
    logic [3:0]  rf_addr;
    logic [31:0] rf_data;
    logic        busy;
    logic        done;
    logic [31:0] rf_mem [16];

    logic        start_sub;
    logic [3:0]  sub_rf_addr;
    logic [31:0] sub_rf_data;
    logic        sub_busy;
    logic        sub_done;
    logic [31:0] sub_mem [16];

    int checks;
    int failures;

    regfile_dump_if main_if ();
    regfile_dump_if sub_if ();

    regfile_dump u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .dump_out (main_if.master),
        .busy     (busy),
        .done     (done)
    );

    regfile_dump #(
        .FIRST_REG (14),
        .LAST_REG  (15)
    ) u_sub (
        .clk      (clk),
        .rst      (rst),
        .start    (start_sub),
        .rf_addr  (sub_rf_addr),
        .rf_data  (sub_rf_data),
        .dump_out (sub_if.master),
        .busy     (sub_busy),
        .done     (sub_done)
    );

    assign rf_data     = rf_mem[rf_addr];
    assign sub_rf_data = sub_mem[sub_rf_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected word for beat b of the full-range dump (checksum beat last).
    function automatic logic [31:0] main_exp_data(input int b);
        if (b < 16) return rf_mem[b];
        return 32'h0000_0003;   // FFFFFFFF + 00000004 mod 2^32
    endfunction

    // Full-range dump: optional stall of stall_len cycles on stall_beat and an
    // optional (ignored) start pulse while restart_beat is presented.
    task automatic run_dump(input string name, input int stall_beat, input int stall_len,
                            input int restart_beat);
        int beat      = 0;
        int stall_cnt = 0;
        int busy_cyc  = 0;
        int dones     = 0;
        int done_cyc  = -1;
        int after     = 0;
        logic [3:0] exp_idx;
        @(negedge clk);
        start = 1'b1;
        main_if.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_value({name, "_first_rd_addr"}, 32'(rf_addr), 32'd0);
        check_value({name, "_first_rd_valid"}, 32'(main_if.out_valid), 32'd0);
        for (int c = 0; c < 400; c++) begin
            if (busy) busy_cyc++;
            if (done) begin
                if (dones == 0) done_cyc = c;
                dones++;
            end
            start = (main_if.out_valid && beat == restart_beat) ? 1'b1 : 1'b0;
            if (main_if.out_valid) begin
                if (beat == stall_beat && stall_cnt < stall_len) begin
                    main_if.out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    main_if.out_ready = 1'b1;
                end
                exp_idx = (beat < 16) ? 4'(beat) : 4'hF;
                check_value({name, "_index"}, 32'(main_if.out_index), 32'(exp_idx));
                check_value({name, "_data"}, main_if.out_data, main_exp_data(beat));
                check_value({name, "_last"}, 32'(main_if.out_last),
                            32'(beat == MAIN_BEATS - 1));
                check_value({name, "_rf_addr"}, 32'(rf_addr), (beat < 16) ? 32'(beat) : 32'd15);
                if (main_if.out_ready) begin
                    $display("%s beat %0d idx=%h data=%h last=%b", name, beat,
                             main_if.out_index, main_if.out_data, main_if.out_last);
                    beat++;
                end
            end
            if (dones > 0) begin
                after++;
                if (after > 3) break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_value({name, "_beats"}, 32'(beat), 32'(MAIN_BEATS));
        check_value({name, "_busy_cycles"}, 32'(busy_cyc), 32'(32 + EXTRA_CYC + stall_len));
        check_value({name, "_done_count"}, 32'(dones), 32'd1);
        check_value({name, "_done_cycle"}, 32'(done_cyc), 32'(32 + EXTRA_CYC + stall_len));
        check_value({name, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    // Subrange instance (14..15): two words, plus the checksum beat if built.
    task automatic run_sub();
        int beat     = 0;
        int busy_cyc = 0;
        int dones    = 0;
        int done_cyc = -1;
        int after    = 0;
        logic [3:0]  exp_idx;
        logic [31:0] exp_data;
        @(negedge clk);
        start_sub = 1'b1;
        sub_if.out_ready = 1'b1;
        @(negedge clk);
        start_sub = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (sub_busy) busy_cyc++;
            if (sub_done) begin
                if (dones == 0) done_cyc = c;
                dones++;
            end
            if (sub_if.out_valid) begin
                exp_idx  = (beat < 2) ? 4'(14 + beat) : 4'hF;
                exp_data = (beat == 0) ? 32'h0000_0000 : 32'hF800_001F;
                check_value("sub_index", 32'(sub_if.out_index), 32'(exp_idx));
                check_value("sub_data", sub_if.out_data, exp_data);
                check_value("sub_last", 32'(sub_if.out_last), 32'(beat == SUB_BEATS - 1));
                $display("sub beat %0d idx=%h data=%h last=%b", beat,
                         sub_if.out_index, sub_if.out_data, sub_if.out_last);
                beat++;
            end
            if (dones > 0) begin
                after++;
                if (after > 3) break;
            end
            @(negedge clk);
        end
        check_value("sub_beats", 32'(beat), 32'(SUB_BEATS));
        check_value("sub_busy_cycles", 32'(busy_cyc), 32'(4 + EXTRA_CYC));
        check_value("sub_done_count", 32'(dones), 32'd1);
        check_value("sub_done_cycle", 32'(done_cyc), 32'(4 + EXTRA_CYC));
    endtask

    initial begin
        int found;
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        start     = 1'b0;
        start_sub = 1'b0;
        main_if.out_ready = 1'b0;
        sub_if.out_ready  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rf_mem[i]  = 32'd0;
            sub_mem[i] = 32'd0;
        end
        rf_mem[1]   = 32'hFFFF_FFFF;
        rf_mem[15]  = 32'h0000_0004;
        sub_mem[15] = 32'hF800_001F;

        // Reset state.
        repeat (2) @(negedge clk);
        check_value("rst_rf_addr", 32'(rf_addr), 32'd0);
        check_value("rst_valid", 32'(main_if.out_valid), 32'd0);
        check_value("rst_data", main_if.out_data, 32'd0);
        check_value("rst_index", 32'(main_if.out_index), 32'd0);
        check_value("rst_last", 32'(main_if.out_last), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_done", 32'(done), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_value("idle_busy", 32'(busy), 32'd0);

        run_dump("basic", -1, 0, -1);
        run_dump("stall", 1, 5, -1);
        run_dump("ignstart", -1, 0, 7);

        // Reset in the middle of word 3's PRESENT cycle.
        @(negedge clk);
        start = 1'b1;
        main_if.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            if (main_if.out_valid && main_if.out_index == 4'd3) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check_value("midrst_reached_w3", 32'(found), 32'd1);
        rst = 1'b0;
        #1;
        check_value("midrst_valid", 32'(main_if.out_valid), 32'd0);
        check_value("midrst_data", main_if.out_data, 32'd0);
        check_value("midrst_index", 32'(main_if.out_index), 32'd0);
        check_value("midrst_last", 32'(main_if.out_last), 32'd0);
        check_value("midrst_rf_addr", 32'(rf_addr), 32'd0);
        check_value("midrst_busy", 32'(busy), 32'd0);
        check_value("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_value("postrst_busy", 32'(busy), 32'd0);
        check_value("postrst_valid", 32'(main_if.out_valid), 32'd0);
        run_dump("afterrst", -1, 0, -1);

        run_sub();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
